// File: rtl/dmem_pkg.sv
// Shared types and helpers for the DMEM arbiter: length encodings, FSM states,
// and the byte count of an access length.
package dmem_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Reserved encoding is reported as 4 bytes; it is rejected separately anyway.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_len_check.sv
// Access legality check (alignment, reserved length, range) and read-data
// masking/zero-extension for one DMEM command.
module dmem_len_check
  import dmem_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = 32,
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MEM_DEPTH         = 8192
) (
  input  logic [WIDTH_ADDR_LENGTH-1:0] addr,
  input  logic [1:0]                   len,
  input  logic [WIDTH_DATA_LENGTH-1:0] datar,
  output logic                         err,
  output logic [WIDTH_DATA_LENGTH-1:0] rdata
);

  typedef logic [WIDTH_ADDR_LENGTH:0] ext_addr_t;

  // One extra bit so an access near the top of the address space cannot wrap.
  ext_addr_t last_byte;

  always_comb begin
    last_byte = {1'b0, addr} + ext_addr_t'(len_bytes(len)) - ext_addr_t'(1);

    case (len)
      LEN_B:   err = 1'b0;
      LEN_H:   err = addr[0];
      LEN_W:   err = (addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    if (last_byte >= ext_addr_t'(MEM_DEPTH))
      err = 1'b1;

    rdata = '0;
    case (len)
      LEN_B:   rdata[7:0]  = datar[7:0];
      LEN_H:   rdata[15:0] = datar[15:0];
      default: rdata       = datar;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and three-cycle access sequencer sharing the DMEM port
// between the load/store unit (port 0) and the DMA/debug port (port 1).
//
//   state  | meaning
//   IDLE   | wait for a request; pick winner and capture its command
//   ACCESS | drive DMEM with the captured command; store commits at exit
//   RESP   | pulse rvalid/err/rdata to the winner
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = 32,
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MEM_DEPTH         = 8192
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        req_i,
  input  logic [1:0]                        we_i,
  input  logic [1:0][WIDTH_ADDR_LENGTH-1:0] addr_i,
  input  logic [1:0][WIDTH_DATA_LENGTH-1:0] wdata_i,
  input  logic [1:0][1:0]                   len_i,
  output logic [1:0]                        gnt_o,
  output logic [1:0]                        rvalid_o,
  output logic [1:0][WIDTH_DATA_LENGTH-1:0] rdata_o,
  output logic [1:0]                        err_o,
  output logic [WIDTH_ADDR_LENGTH-1:0]      mem_addr_o,
  output logic [WIDTH_DATA_LENGTH-1:0]      mem_dataw_o,
  output logic                              mem_memrw_o,
  output logic [1:0]                        mem_lensel_o,
  input  logic [WIDTH_DATA_LENGTH-1:0]      mem_datar_i
);

  state_t                         state, state_nxt;
  logic                           last_gnt;
  logic                           sel;
  logic                           cmd_port;
  logic                           cmd_we;
  logic [WIDTH_ADDR_LENGTH-1:0]   cmd_addr;
  logic [WIDTH_DATA_LENGTH-1:0]   cmd_wdata;
  logic [1:0]                     cmd_len;
  logic                           cmd_err;
  logic [WIDTH_DATA_LENGTH-1:0]   chk_rdata;
  logic [WIDTH_DATA_LENGTH-1:0]   rdata_q;

  // On a tie the port that did not win last time goes next.
  assign sel = (req_i[0] & req_i[1]) ? ~last_gnt : req_i[1];

  dmem_len_check #(
    .WIDTH_ADDR_LENGTH (WIDTH_ADDR_LENGTH),
    .WIDTH_DATA_LENGTH (WIDTH_DATA_LENGTH),
    .MEM_DEPTH         (MEM_DEPTH)
  ) u_len_check (
    .addr  (cmd_addr),
    .len   (cmd_len),
    .datar (mem_datar_i),
    .err   (cmd_err),
    .rdata (chk_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_i) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_len   <= LEN_B;
      rdata_q   <= '0;
    end else begin
      if (state == IDLE && |req_i) begin
        last_gnt  <= sel;
        cmd_port  <= sel;
        cmd_we    <= we_i[sel];
        cmd_addr  <= addr_i[sel];
        cmd_wdata <= wdata_i[sel];
        cmd_len   <= len_i[sel];
      end
      if (state == ACCESS)
        rdata_q <= (cmd_we | cmd_err) ? '0 : chk_rdata;
    end
  end

  // All outputs decode from registered state, so reset clears them at once.
  always_comb begin
    gnt_o        = '0;
    rvalid_o     = '0;
    err_o        = '0;
    rdata_o      = '0;
    mem_addr_o   = '0;
    mem_dataw_o  = '0;
    mem_memrw_o  = 1'b0;
    mem_lensel_o = '0;
    case (state)
      ACCESS: begin
        gnt_o[cmd_port] = 1'b1;
        mem_addr_o      = cmd_addr;
        mem_dataw_o     = cmd_wdata;
        mem_lensel_o    = cmd_len;
        mem_memrw_o     = cmd_we & ~cmd_err;
      end
      RESP: begin
        rvalid_o[cmd_port] = 1'b1;
        err_o[cmd_port]    = cmd_err;
        rdata_o[cmd_port]  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-array DMEM model.
module tb_dmem_arbiter;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            req, we;
  logic [1:0][31:0]      addr, wdata;
  logic [1:0][1:0]       len;
  logic [1:0]            gnt, rvalid, err;
  logic [1:0][31:0]      rdata;
  logic [31:0]           mem_addr, mem_dataw, mem_datar;
  logic                  mem_memrw;
  logic [1:0]            mem_lensel;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rv_cnt = 0;
  int gnt0_cnt = 0;
  int overlap_cnt = 0;
  int cyc = 0;

  logic [7:0]  mem [0:8191];
  logic [12:0] a0, a1, a2, a3;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .WIDTH_ADDR_LENGTH (32),
    .WIDTH_DATA_LENGTH (32),
    .MEM_DEPTH         (8192)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .len_i        (len),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .err_o        (err),
    .mem_addr_o   (mem_addr),
    .mem_dataw_o  (mem_dataw),
    .mem_memrw_o  (mem_memrw),
    .mem_lensel_o (mem_lensel),
    .mem_datar_i  (mem_datar)
  );

  assign a0 = mem_addr[12:0];
  assign a1 = a0 + 13'd1;
  assign a2 = a0 + 13'd2;
  assign a3 = a0 + 13'd3;
  assign mem_datar = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_memrw) begin
      wr_cnt <= wr_cnt + 1;
      mem[a0] <= mem_dataw[7:0];
      if (mem_lensel != 2'b00) mem[a1] <= mem_dataw[15:8];
      if (mem_lensel == 2'b11) begin
        mem[a2] <= mem_dataw[23:16];
        mem[a3] <= mem_dataw[31:24];
      end
    end
  end

  always @(negedge clk) begin
    if (gnt != 2'b00 && rvalid != 2'b00) overlap_cnt++;
    if (gnt[0]) gnt0_cnt++;
    if (rvalid != 2'b00) rv_cnt++;
  end

  // Called just after a rising edge; returns at the start of the cycle after RESP.
  task automatic access(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] l,
                        output int t_gnt, output int t_rv, output int rv_at,
                        output logic [31:0] rd, output logic e);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; len[p] = l;
    t_gnt = -1; t_rv = -1; rv_at = -1; rd = 'x; e = 1'bx;
    for (int c = 0; c < 10 && t_rv < 0; c++) begin
      @(negedge clk);
      if (gnt[p] && t_gnt < 0) t_gnt = c;
      if (rvalid[p]) begin t_rv = c; rv_at = cyc; rd = rdata[p]; e = err[p]; end
      @(posedge clk); #1;
      if (t_gnt >= 0) req[p] = 1'b0;
    end
    req[p] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, rvalid, err, rdata, mem_addr, mem_dataw, mem_memrw, mem_lensel} !== '0)
      begin errors++; $display("FAIL reset_outputs: got gnt=%b rv=%b memrw=%b, expected all zero", gnt, rvalid, mem_memrw); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    int tg, tr, ra, w0; logic [31:0] rd; logic e;
    w0 = wr_cnt;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, tg, tr, ra, rd, e);
    checks++; if (tg !== 1) begin errors++; $display("FAIL store_gnt_time: got %0d expected 1", tg); end
    checks++; if (tr !== 2) begin errors++; $display("FAIL store_rvalid_time: got %0d expected 2", tr); end
    checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_resp: err=%b rdata=%h expected err=0 rdata=0", e, rd); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL store_memrw_cycles: got %0d expected 1", wr_cnt - w0); end
    access(0, 1'b0, 32'h10, 32'h0, 2'b11, tg, tr, ra, rd, e);
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL load_word_0x10: got %h err=%b expected deadbeef", rd, e); end
  endtask

  task automatic test_lengths;
    int tg, tr, ra; logic [31:0] rd; logic e;
    access(1, 1'b0, 32'h11, 32'h0, 2'b00, tg, tr, ra, rd, e);
    checks++; if (rd !== 32'h000000BE || e !== 1'b0) begin errors++; $display("FAIL byte_load_0x11: got %h expected 000000be", rd); end
    access(1, 1'b0, 32'h12, 32'h0, 2'b01, tg, tr, ra, rd, e);
    checks++; if (rd !== 32'h0000DEAD || e !== 1'b0) begin errors++; $display("FAIL half_load_0x12: got %h expected 0000dead", rd); end
    access(0, 1'b1, 32'h18, 32'h12345655, 2'b00, tg, tr, ra, rd, e);
    access(0, 1'b0, 32'h18, 32'h0, 2'b11, tg, tr, ra, rd, e);
    checks++; if (rd !== 32'h00000055) begin errors++; $display("FAIL byte_store_readback: got %h expected 00000055", rd); end
    access(1, 1'b0, 32'h1FFC, 32'h0, 2'b11, tg, tr, ra, rd, e);
    checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL top_word_in_range: err=%b rdata=%h expected err=0 rdata=0", e, rd); end
  endtask

  task automatic test_errors;
    int tg, tr, ra, w0; logic [31:0] rd; logic e;
    logic [31:0] ea [4];
    logic [1:0]  el [4];
    ea = '{32'h13, 32'h21, 32'h30, 32'h1FFE};
    el = '{2'b11, 2'b01, 2'b10, 2'b11};
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      access(i % 2, 1'b1, ea[i], 32'hA5A5A5A5, el[i], tg, tr, ra, rd, e);
      checks++;
      if (e !== 1'b1 || tr !== 2 || rd !== 32'h0)
        begin errors++; $display("FAIL err_access_%0d: err=%b t_rv=%0d rdata=%h expected err=1 t_rv=2 rdata=0", i, e, tr, rd); end
    end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL err_no_write: got %0d writes expected 0", wr_cnt - w0); end
    access(0, 1'b0, 32'h10, 32'h0, 2'b11, tg, tr, ra, rd, e);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_readback_0x10: got %h expected deadbeef", rd); end
    access(1, 1'b0, 32'h20, 32'h0, 2'b11, tg, tr, ra, rd, e);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_readback_0x20: got %h expected 0", rd); end
  endtask

  task automatic test_reset_mid_access;
    int tg, tr, ra, w0, r0; logic [31:0] rd; logic e;
    w0 = wr_cnt;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678; len[0] = 2'b11;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_memrw !== 1'b1 || gnt[0] !== 1'b1)
      begin errors++; $display("FAIL abort_in_access: memrw=%b gnt0=%b expected 1 1", mem_memrw, gnt[0]); end
    #1 rst_n = 1'b0; req[0] = 1'b0;
    #1;
    checks++;
    if ({gnt, rvalid, err, rdata, mem_addr, mem_dataw, mem_memrw, mem_lensel} !== '0)
      begin errors++; $display("FAIL abort_outputs: memrw=%b gnt=%b addr=%h expected all zero", mem_memrw, gnt, mem_addr); end
    r0 = rv_cnt;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (wr_cnt !== w0 || rv_cnt !== r0)
      begin errors++; $display("FAIL abort_no_write_no_rvalid: writes=%0d rvalids=%0d expected 0 0", wr_cnt - w0, rv_cnt - r0); end
    @(posedge clk); #1;
    access(1, 1'b0, 32'h40, 32'h0, 2'b11, tg, tr, ra, rd, e);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_readback_0x40: got %h expected 0", rd); end
  endtask

  // Runs with last_gnt at its reset value, so port 0 must win the first tie.
  task automatic test_round_robin;
    int gp[$]; int gc[$];
    req = 2'b11; we = 2'b00;
    addr[0] = 32'h10; len[0] = 2'b11;
    addr[1] = 32'h12; len[1] = 2'b01;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt[0]) begin gp.push_back(0); gc.push_back(c); end
      if (gnt[1]) begin gp.push_back(1); gc.push_back(c); end
      if (rvalid[0]) begin
        checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_rdata0: got %h expected deadbeef", rdata[0]); end
      end
      if (rvalid[1]) begin
        checks++; if (rdata[1] !== 32'h0000DEAD) begin errors++; $display("FAIL rr_rdata1: got %h expected 0000dead", rdata[1]); end
      end
      @(posedge clk); #1;
    end
    req = 2'b00;
    checks++;
    if (gp.size() != 4) begin
      errors++; $display("FAIL rr_grant_count: got %0d expected 4", gp.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gp[i] != i % 2 || gc[i] != 1 + 3 * i)
          begin errors++; $display("FAIL rr_grant_%0d: port %0d at cycle %0d expected port %0d at cycle %0d", i, gp[i], gc[i], i % 2, 1 + 3 * i); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int tg, tr, ra, g0, prev_at; logic [31:0] rd; logic e;
    logic [31:0] ba [3];
    logic [1:0]  bl [3];
    logic [31:0] bx [3];
    ba = '{32'h13, 32'h10, 32'h10};
    bl = '{2'b00, 2'b01, 2'b11};
    bx = '{32'h000000DE, 32'h0000BEEF, 32'hDEADBEEF};
    g0 = gnt0_cnt;
    prev_at = -1;
    for (int i = 0; i < 3; i++) begin
      access(1, 1'b0, ba[i], 32'h0, bl[i], tg, tr, ra, rd, e);
      checks++;
      if (rd !== bx[i] || tr !== 2 || (prev_at >= 0 && ra - prev_at != 3))
        begin errors++; $display("FAIL b2b_%0d: rdata=%h t_rv=%0d spacing=%0d expected %h 2 3", i, rd, tr, ra - prev_at, bx[i]); end
      prev_at = ra;
    end
    checks++; if (gnt0_cnt !== g0) begin errors++; $display("FAIL b2b_no_gnt0: got %0d grants expected 0", gnt0_cnt - g0); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    test_reset();
    test_store_load();
    test_lengths();
    test_errors();
    test_reset_mid_access();
    test_round_robin();
    test_back_to_back();
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL gnt_rvalid_overlap: got %0d cycles expected 0", overlap_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
